mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Multi-cycle sequencer for LW/SW, placed between decode, the register file and the data memory.
//  Reads the base and target registers and forms the halfword-aligned address.
//  Drives a req/ack memory handshake, then writes load data back to the register file.
//  Holds off a new op while busy and aborts on a memory timeout.
// PARAMETERS
//  DW       16  data and address width
//  RW       4   register index width
//  TIMEOUT  64  max cycles in MEM without ack before abort (0 = never time out)
// PORTS
//  clk        in   1   system clock, single domain
//  rst        in   1   reset, synchronous, active-high
//  start      in   1   op request; sampled only in IDLE
//  mode       in   1   0=LW, 1=SW
//  base_reg   in   RW  base register index
//  target_reg in   RW  LW destination / SW source index
//  offset     in   4   signed word offset
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle completion pulse
//  err        out  1   one-cycle pulse together with done when an op times out
//  rf_raddr1  out  RW  register-file read port 1 (base)
//  rf_raddr2  out  RW  register-file read port 2 (target)
//  rf_rdata1  in   DW  combinational read data, port 1
//  rf_rdata2  in   DW  combinational read data, port 2
//  rf_we      out  1   writeback strobe
//  rf_waddr   out  RW  writeback index
//  rf_wdata   out  DW  writeback data
//  mem_req    out  1   memory request, held until ack
//  mem_we     out  1   1 = write
//  mem_addr   out  DW  byte address
//  mem_wdata  out  DW  store data
//  mem_rdata  in   DW  load data, valid with mem_ack
//  mem_ack    in   1   one-cycle completion from memory
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-op drops mem_req at the next edge, no writeback.
//  FSM IDLE -> ADDR -> MEM -> FIN -> IDLE.
//   IDLE: on start, capture mode/base_reg/target_reg/offset; start in any other state is ignored.
//   ADDR: rf_raddr1/2 = captured indices.
//    Register addr = (rf_rdata1 & 16'hFFFE) + (sext16(offset) << 1), mod 2^16 (wraps, no flag).
//    Register wdata = rf_rdata2.
//   MEM: mem_req=1; mem_we=mode; mem_addr/mem_wdata stay stable until ack.
//    Ack in the first MEM cycle is legal. On ack, a LW latches mem_rdata; go FIN.
//    Counter increments per MEM cycle without ack. When it reaches TIMEOUT, set err_flag and go FIN without a write.
//   FIN: done=1; err=err_flag.
//    rf_we=1 only if LW, no error, and target_reg!=0 (R0 writes are suppressed).
//    rf_waddr=target_reg; rf_wdata=latched data. Then IDLE.
//  Latency start->done = 3 + (cycles waiting for ack); minimum 3.
//  mem_ack outside MEM is ignored. mem_rdata is sampled only with ack in MEM.
//  busy falls in the same cycle as done's falling edge, so back-to-back: start may be asserted the cycle after FIN.
//  All outputs are registered or decoded from state only; there is no combinational path from start or ack to outputs.
// STRUCTURE
//  Package mem_ctrl_pkg: state enum {IDLE,ADDR,MEM,FIN}, MODE_LW=0/MODE_SW=1, DW/RW constants.
//  Sub-module mem_addr_gen: combinational (base, offset) -> aligned byte address; reused by the pipelined core later.
// TESTING
//  LW: R2=0x1000, off=+3, mem ack after 2 cycles with 0xBEEF -> mem_addr=0x1006, mem_we=0, rf_we to target with 0xBEEF, done at cycle 5.
//  SW: R3=0x0101, R4=0x1234, off=-1, ack in the same cycle as req -> mem_addr=0x00FE, mem_wdata=0x1234, rf_we never asserted, done at cycle 3.
//  Wrap: base=0xFFFE, off=+1 -> mem_addr=0x0000; base=0x0001, off=-8 -> mem_addr=0xFFF0.
//  LW to R0 -> full handshake, done pulses, rf_we stays 0.
//  No ack, TIMEOUT=4 -> mem_req high exactly 4 cycles, then done=err=1 for one cycle, no writeback, busy=0.
//  rst asserted in MEM -> next cycle mem_req=0, busy=0, done=0; start during busy is ignored; ack while IDLE has no effect.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the LW/SW memory-access sequencer.
package mem_ctrl_pkg;
    localparam int DW   = 16;
    localparam int RW   = 4;
    localparam int OFFW = 4;

    localparam logic MODE_LW = 1'b0;
    localparam logic MODE_SW = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        MEM  = 2'd2,
        FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/mem_addr_gen.sv
// Halfword-aligned byte address from a base register and a signed word offset.
module mem_addr_gen
    import mem_ctrl_pkg::*;
#(
    parameter int AW = mem_ctrl_pkg::DW
) (
    input  logic [AW-1:0]   base,
    input  logic [OFFW-1:0] offset,
    output logic [AW-1:0]   addr
);
    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-1){1'b1}}, 1'b0};

    logic [AW-1:0] off_ext;

    assign off_ext = {{(AW-OFFW){offset[OFFW-1]}}, offset};
    // Sum wraps modulo 2^AW; no overflow indication is wanted.
    assign addr    = (base & ALIGN_MASK) + (off_ext << 1);
endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle LW/SW sequencer: register read, address formation, req/ack memory
// handshake with timeout abort, and register-file writeback for loads.
//
//  state | meaning
//  IDLE  | waiting for start; op fields captured on start
//  ADDR  | base/target registers read, address and store data registered
//  MEM   | mem_req held until ack or timeout
//  FIN   | one-cycle done (and err on timeout); load writeback strobe
module mem_access_ctrl #(
    parameter int DW      = mem_ctrl_pkg::DW,
    parameter int RW      = mem_ctrl_pkg::RW,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [RW-1:0] base_reg,
    input  logic [RW-1:0] target_reg,
    input  logic [3:0]    offset,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [RW-1:0] rf_raddr1,
    output logic [RW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic          rf_we,
    output logic [RW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);
    import mem_ctrl_pkg::*;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          mode_q;
    logic [RW-1:0] base_q, target_q;
    logic [3:0]    offset_q;
    logic [DW-1:0] addr_q, wdata_q, rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] addr_calc;
    logic          timeout_hit;

    mem_addr_gen #(.AW(DW)) u_addr_gen (
        .base   (rf_rdata1),
        .offset (offset_q),
        .addr   (addr_calc)
    );

    // Fires on the MEM cycle whose un-acked count would reach TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && !mem_ack && (cnt_q == TC);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rf_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = ADDR;
            ADDR: begin
                busy      = 1'b1;
                state_nxt = MEM;
            end
            MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = mode_q;
                if (mem_ack || timeout_hit) state_nxt = FIN;
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                err       = err_q;
                rf_we     = (mode_q == MODE_LW) && !err_q && (target_q != '0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            base_q   <= '0;
            target_q <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_q   <= mode;
                    base_q   <= base_reg;
                    target_q <= target_reg;
                    offset_q <= offset;
                end
                ADDR: begin
                    addr_q  <= addr_calc;
                    wdata_q <= rf_rdata2;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end
                MEM: begin
                    if (mem_ack) begin
                        if (mode_q == MODE_LW) rdata_q <= mem_rdata;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (timeout_hit) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_raddr1 = base_q;
    assign rf_raddr2 = target_q;
    assign rf_waddr  = target_q;
    assign rf_wdata  = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural register file and ack responder.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic [3:0]  base_reg, target_reg, offset;
    logic        busy, done, err, rf_we, mem_req, mem_we, mem_ack;
    logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [15:0] rf_rdata1, rf_rdata2, rf_wdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] regs [16];

    int checks   = 0;
    int failures = 0;

    // Results recorded by do_op
    int          lat, req_cnt, we_cnt;
    logic [15:0] seen_addr, seen_wdata, seen_rf_wdata;
    logic [3:0]  seen_waddr;
    logic        seen_we, addr_stable, seen_err, seen_done;

    mem_access_ctrl #(.DW(16), .RW(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .base_reg(base_reg), .target_reg(target_reg), .offset(offset),
        .busy(busy), .done(done), .err(err),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one op; ack is given in MEM cycle number ack_after+1, or never if no_ack.
    task automatic do_op(input logic m, input logic [3:0] b, input logic [3:0] t,
                         input logic [3:0] o, input int ack_after, input logic no_ack,
                         input logic [15:0] rdata);
        lat = 0; req_cnt = 0; we_cnt = 0; addr_stable = 1'b1;
        seen_addr = '0; seen_wdata = '0; seen_we = 1'b0; seen_waddr = '0;
        seen_rf_wdata = '0; seen_err = 1'b0; seen_done = 1'b0;
        start = 1'b1; mode = m; base_reg = b; target_reg = t; offset = o;
        for (int i = 0; i < 30; i++) begin
            tick();
            lat++;
            start = 1'b0;
            mem_ack = 1'b0;
            mem_rdata = 16'h0000;
            if (mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    seen_addr = mem_addr; seen_wdata = mem_wdata; seen_we = mem_we;
                end else if (mem_addr !== seen_addr || mem_wdata !== seen_wdata) begin
                    addr_stable = 1'b0;
                end
                if (!no_ack && req_cnt == ack_after + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (rf_we) begin
                we_cnt++; seen_waddr = rf_waddr; seen_rf_wdata = rf_wdata;
            end
            if (done) begin
                seen_done = 1'b1; seen_err = err;
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, err, rf_we, mem_req, mem_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000", {busy, done, err, rf_we, mem_req, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, rf_wdata} !== 48'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, rf_wdata});
        end
    endtask

    task automatic test_lw();
        regs[2] = 16'h1000;
        do_op(1'b0, 4'd2, 4'd5, 4'd3, 2, 1'b0, 16'hBEEF);
        checks++;
        if (seen_addr !== 16'h1006) begin failures++; $display("FAIL lw_addr got=%h want=1006", seen_addr); end
        checks++;
        if (seen_we !== 1'b0) begin failures++; $display("FAIL lw_mem_we got=%b want=0", seen_we); end
        checks++;
        if (lat !== 5 || !seen_done) begin failures++; $display("FAIL lw_latency got=%0d want=5", lat); end
        checks++;
        if (we_cnt !== 1 || seen_waddr !== 4'd5 || seen_rf_wdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL lw_writeback got cnt=%0d addr=%0d data=%h want cnt=1 addr=5 data=beef",
                     we_cnt, seen_waddr, seen_rf_wdata);
        end
        checks++;
        if (addr_stable !== 1'b1 || req_cnt !== 3) begin
            failures++;
            $display("FAIL lw_req got stable=%b cycles=%0d want stable=1 cycles=3", addr_stable, req_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL lw_after got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_sw();
        regs[3] = 16'h0101;
        regs[4] = 16'h1234;
        do_op(1'b1, 4'd3, 4'd4, 4'hF, 0, 1'b0, 16'hFFFF);
        checks++;
        if (seen_addr !== 16'h00FE || seen_wdata !== 16'h1234) begin
            failures++;
            $display("FAIL sw_addr_data got=%h/%h want=00fe/1234", seen_addr, seen_wdata);
        end
        checks++;
        if (seen_we !== 1'b1) begin failures++; $display("FAIL sw_mem_we got=%b want=1", seen_we); end
        checks++;
        if (we_cnt !== 0) begin failures++; $display("FAIL sw_no_rf_we got=%0d want=0", we_cnt); end
        checks++;
        if (lat !== 3 || seen_err !== 1'b0) begin
            failures++;
            $display("FAIL sw_latency got=%0d err=%b want=3 err=0", lat, seen_err);
        end
        tick();
    endtask

    task automatic test_wrap();
        regs[6] = 16'hFFFE;
        do_op(1'b0, 4'd6, 4'd8, 4'd1, 0, 1'b0, 16'h5A5A);
        checks++;
        if (seen_addr !== 16'h0000) begin failures++; $display("FAIL wrap_up got=%h want=0000", seen_addr); end
        checks++;
        if (we_cnt !== 1 || seen_rf_wdata !== 16'h5A5A) begin
            failures++;
            $display("FAIL wrap_wb got cnt=%0d data=%h want 1 5a5a", we_cnt, seen_rf_wdata);
        end
        tick();
        regs[7] = 16'h0001;
        do_op(1'b1, 4'd7, 4'd6, 4'h8, 1, 1'b0, 16'h0000);
        checks++;
        if (seen_addr !== 16'hFFF0) begin failures++; $display("FAIL wrap_down got=%h want=fff0", seen_addr); end
        tick();
    endtask

    task automatic test_r0();
        do_op(1'b0, 4'd2, 4'd0, 4'd0, 1, 1'b0, 16'hCAFE);
        checks++;
        if (!seen_done || lat !== 4 || req_cnt !== 2) begin
            failures++;
            $display("FAIL r0_handshake got lat=%0d req=%0d want 4 2", lat, req_cnt);
        end
        checks++;
        if (we_cnt !== 0) begin failures++; $display("FAIL r0_no_write got=%0d want=0", we_cnt); end
        tick();
    endtask

    task automatic test_timeout();
        do_op(1'b0, 4'd2, 4'd9, 4'd0, 0, 1'b1, 16'h0000);
        checks++;
        if (req_cnt !== 4) begin failures++; $display("FAIL to_req_cycles got=%0d want=4", req_cnt); end
        checks++;
        if (!seen_done || seen_err !== 1'b1 || lat !== 6) begin
            failures++;
            $display("FAIL to_done_err got done=%b err=%b lat=%0d want 1 1 6", seen_done, seen_err, lat);
        end
        checks++;
        if (we_cnt !== 0) begin failures++; $display("FAIL to_no_write got=%0d want=0", we_cnt); end
        tick();
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++;
            $display("FAIL to_after got=%b want=000", {busy, done, err});
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; mode = 1'b0; base_reg = 4'd2; target_reg = 4'd5; offset = 4'd0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_in_mem got=%b want=1", mem_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_req, busy, done, rf_we} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_after got=%b want=0000", {mem_req, busy, done, rf_we});
        end
        tick();
    endtask

    task automatic test_busy_start();
        regs[10] = 16'h2000;
        regs[11] = 16'h4444;
        start = 1'b1; mode = 1'b0; base_reg = 4'd10; target_reg = 4'd12; offset = 4'd2;
        tick();
        mode = 1'b1; base_reg = 4'd11; target_reg = 4'd13; offset = 4'd7;
        tick();
        checks++;
        if (mem_addr !== 16'h2004 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_addr got=%h we=%b want=2004 we=0", mem_addr, mem_we);
        end
        start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 4'd12 || rf_wdata !== 16'h7777) begin
            failures++;
            $display("FAIL busy_start_fin got done=%b we=%b addr=%0d data=%h want 1 1 12 7777",
                     done, rf_we, rf_waddr, rf_wdata);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_queued got=%b want=0", busy); end
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick(); tick(); tick();
        mem_ack = 1'b0;
        checks++;
        if ({busy, done, rf_we, mem_req} !== 4'b0000 || rf_wdata === 16'hDEAD) begin
            failures++;
            $display("FAIL ack_idle got=%b wdata=%h want=0000 and not dead",
                     {busy, done, rf_we, mem_req}, rf_wdata);
        end
    endtask

    task automatic test_back_to_back();
        regs[1] = 16'h0300;
        do_op(1'b0, 4'd1, 4'd14, 4'd0, 0, 1'b0, 16'h1111);
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b want=0", busy); end
        do_op(1'b0, 4'd1, 4'd15, 4'd1, 0, 1'b0, 16'h2222);
        checks++;
        if (lat !== 3 || seen_addr !== 16'h0302 || seen_waddr !== 4'd15 || seen_rf_wdata !== 16'h2222) begin
            failures++;
            $display("FAIL b2b_second got lat=%0d addr=%h wa=%0d wd=%h want 3 0302 15 2222",
                     lat, seen_addr, seen_waddr, seen_rf_wdata);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h0111);
        rst = 1'b0; start = 1'b0; mode = 1'b0; base_reg = '0; target_reg = '0; offset = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_lw();
        test_sw();
        test_wrap();
        test_r0();
        test_timeout();
        test_reset_mid();
        test_busy_start();
        test_ack_idle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
